rob_retire: RTL and testbench

ROB_RETIRE -- requirements
Module: rob_retire

---
 rtl/rob_retire_if.sv | 33 +++
 rtl/rob_retire.sv | 104 ++++++++++
 tb/tb_rob_retire.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/rob_retire_if.sv
// rob_retire_if: dispatch, completion and free-list bundle of the reorder buffer.
//   master: dispatch requests and completion strobes out; ready/indices/frees in.
//   slave : the reorder buffer side.
interface rob_retire_if #(
    parameter int IW = 4
);
    logic          disp_valid_1, disp_valid_2;
    logic          disp_has_rd_1, disp_has_rd_2;
    logic [5:0]    disp_old_pd_1, disp_old_pd_2;
    logic          disp_ready;
    logic [IW-1:0] rob_idx_1, rob_idx_2;
    logic          cmp_valid_1, cmp_valid_2;
    logic [IW-1:0] cmp_idx_1, cmp_idx_2;
    logic [5:0]    regFree1, regFree2;
    logic          regFree1_valid, regFree2_valid;
    logic          rob_empty;

    modport master (
        output disp_valid_1, disp_valid_2, disp_has_rd_1, disp_has_rd_2,
               disp_old_pd_1, disp_old_pd_2, cmp_valid_1, cmp_valid_2,
               cmp_idx_1, cmp_idx_2,
        input  disp_ready, rob_idx_1, rob_idx_2, regFree1, regFree2,
               regFree1_valid, regFree2_valid, rob_empty
    );

    modport slave (
        input  disp_valid_1, disp_valid_2, disp_has_rd_1, disp_has_rd_2,
               disp_old_pd_1, disp_old_pd_2, cmp_valid_1, cmp_valid_2,
               cmp_idx_1, cmp_idx_2,
        output disp_ready, rob_idx_1, rob_idx_2, regFree1, regFree2,
               regFree1_valid, regFree2_valid, rob_empty
    );
endinterface

// File: rtl/rob_retire.sv
// rob_retire: two-wide in-order reorder buffer that returns old physical registers on retire.
//   clk, rst : clock and synchronous active-high reset
//   rob      : slave side of rob_retire_if (dispatch in, completion in, register frees out)
module rob_retire #(
    parameter int DEPTH = 16,
    parameter int IW    = 4
) (
    input logic         clk,
    input logic         rst,
    rob_retire_if.slave rob
);
    logic          valid_q  [DEPTH];
    logic          done_q   [DEPTH];
    logic          has_rd_q [DEPTH];
    logic [5:0]    old_pd_q [DEPTH];
    logic [IW-1:0] head_q, head_d, tail_q, tail_d, head1, tail1;
    logic [IW:0]   count_q, count_d;
    logic [5:0]    free1_q, free1_d, free2_q, free2_d;
    logic          free1_v_q, free1_v_d, free2_v_q, free2_v_d;
    logic          disp_1, disp_2, ret_a, ret_b;

    // Retire looks only at registered done bits, so completion never bypasses into retire.
    always_comb begin
        head1     = head_q + IW'(1);
        tail1     = tail_q + IW'(1);
        disp_1    = rob.disp_ready && rob.disp_valid_1;
        disp_2    = disp_1 && rob.disp_valid_2;
        ret_a     = valid_q[head_q] && done_q[head_q];
        ret_b     = ret_a && valid_q[head1] && done_q[head1];
        tail_d    = tail_q + IW'(disp_1) + IW'(disp_2);
        head_d    = head_q + IW'(ret_a) + IW'(ret_b);
        count_d   = count_q + (IW+1)'(disp_1) + (IW+1)'(disp_2)
                  - (IW+1)'(ret_a) - (IW+1)'(ret_b);
        free1_v_d = ret_a && has_rd_q[head_q] && old_pd_q[head_q] != 6'd0;
        free2_v_d = ret_b && has_rd_q[head1] && old_pd_q[head1] != 6'd0;
        free1_d   = free1_v_d ? old_pd_q[head_q] : 6'd0;
        free2_d   = free2_v_d ? old_pd_q[head1] : 6'd0;
    end

    assign rob.disp_ready     = count_q <= (IW+1)'(DEPTH - 2);
    assign rob.rob_empty      = count_q == '0;
    assign rob.rob_idx_1      = tail_q;
    assign rob.rob_idx_2      = tail1;
    assign rob.regFree1       = free1_q;
    assign rob.regFree2       = free2_q;
    assign rob.regFree1_valid = free1_v_q;
    assign rob.regFree2_valid = free2_v_q;

    // Dispatch only ever targets free slots (at most DEPTH-2 occupied), so it never
    // collides with the retiring head entries; retire clear is ordered after completion.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
            free1_q   <= 6'd0;
            free2_q   <= 6'd0;
            free1_v_q <= 1'b0;
            free2_v_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                valid_q[i] <= 1'b0;
                done_q[i]  <= 1'b0;
            end
        end else begin
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
            free1_q   <= free1_d;
            free2_q   <= free2_d;
            free1_v_q <= free1_v_d;
            free2_v_q <= free2_v_d;
            if (rob.cmp_valid_1 && valid_q[rob.cmp_idx_1]) done_q[rob.cmp_idx_1] <= 1'b1;
            if (rob.cmp_valid_2 && valid_q[rob.cmp_idx_2]) done_q[rob.cmp_idx_2] <= 1'b1;
            if (ret_a) begin
                valid_q[head_q] <= 1'b0;
                done_q[head_q]  <= 1'b0;
            end
            if (ret_b) begin
                valid_q[head1] <= 1'b0;
                done_q[head1]  <= 1'b0;
            end
            if (disp_1) begin
                valid_q[tail_q] <= 1'b1;
                done_q[tail_q]  <= 1'b0;
            end
            if (disp_2) begin
                valid_q[tail1] <= 1'b1;
                done_q[tail1]  <= 1'b0;
            end
        end
    end

    // Payload needs no reset: it is only read through a valid entry.
    always_ff @(posedge clk) begin
        if (!rst && disp_1) begin
            has_rd_q[tail_q] <= rob.disp_has_rd_1;
            old_pd_q[tail_q] <= rob.disp_old_pd_1;
        end
        if (!rst && disp_2) begin
            has_rd_q[tail1] <= rob.disp_has_rd_2;
            old_pd_q[tail1] <= rob.disp_old_pd_2;
        end
    end
endmodule

// File: tb/tb_rob_retire.sv
// tb_rob_retire: table-driven and directed checks of the rob_retire reorder buffer.
module tb_rob_retire;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    rob_retire_if #(.IW(4)) bus ();

    rob_retire #(.DEPTH(16), .IW(4)) dut (
        .clk(clk),
        .rst(rst),
        .rob(bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       dv1, dv2, hr1, hr2;
        logic [5:0] pd1, pd2;
        logic       cv1, cv2;
        logic [3:0] ci1, ci2;
        logic       rdy, emp;
        logic [3:0] idx1;
        logic       f1v;
        logic [5:0] f1;
        logic       f2v;
        logic [5:0] f2;
    } vec_t;

    vec_t       vt [19];
    logic [5:0] q [$];
    logic [5:0] e1, e2;
    logic [3:0] hm, tm;

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic dv1, dv2, hr1, hr2, input logic [5:0] pd1, pd2,
                         input logic cv1, cv2, input logic [3:0] ci1, ci2);
        bus.disp_valid_1  = dv1;
        bus.disp_valid_2  = dv2;
        bus.disp_has_rd_1 = hr1;
        bus.disp_has_rd_2 = hr2;
        bus.disp_old_pd_1 = pd1;
        bus.disp_old_pd_2 = pd2;
        bus.cmp_valid_1   = cv1;
        bus.cmp_valid_2   = cv2;
        bus.cmp_idx_1     = ci1;
        bus.cmp_idx_2     = ci2;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 6'd0, 6'd0, 0, 0, 4'd0, 4'd0);
    endtask

    task automatic chk_out(input string tag, input logic rdy, emp, input logic [3:0] idx1,
                           input logic f1v, input logic [5:0] f1, input logic f2v,
                           input logic [5:0] f2);
        logic [3:0] idx2;
        idx2 = idx1 + 4'd1;
        chk({tag, " disp_ready"}, int'(bus.disp_ready), int'(rdy));
        chk({tag, " rob_empty"}, int'(bus.rob_empty), int'(emp));
        chk({tag, " rob_idx_1"}, int'(bus.rob_idx_1), int'(idx1));
        chk({tag, " rob_idx_2"}, int'(bus.rob_idx_2), int'(idx2));
        chk({tag, " regFree1_valid"}, int'(bus.regFree1_valid), int'(f1v));
        chk({tag, " regFree1"}, int'(bus.regFree1), int'(f1));
        chk({tag, " regFree2_valid"}, int'(bus.regFree2_valid), int'(f2v));
        chk({tag, " regFree2"}, int'(bus.regFree2), int'(f2));
    endtask

    initial begin
        //        dv1 dv2 hr1 hr2 pd1    pd2    cv1 cv2 ci1   ci2   rdy emp idx1  f1v f1     f2v f2
        vt[0]  = '{1, 1, 1, 1, 6'd5,  6'd7,  0, 0, 4'd0, 4'd0, 1, 0, 4'd2, 0, 6'd0,  0, 6'd0};
        vt[1]  = '{0, 0, 0, 0, 6'd0,  6'd0,  1, 1, 4'd0, 4'd1, 1, 0, 4'd2, 0, 6'd0,  0, 6'd0};
        vt[2]  = '{0, 0, 0, 0, 6'd0,  6'd0,  0, 0, 4'd0, 4'd0, 1, 1, 4'd2, 1, 6'd5,  1, 6'd7};
        vt[3]  = '{0, 0, 0, 0, 6'd0,  6'd0,  0, 0, 4'd0, 4'd0, 1, 1, 4'd2, 0, 6'd0,  0, 6'd0};
        vt[4]  = '{1, 1, 1, 1, 6'd9,  6'd11, 0, 0, 4'd0, 4'd0, 1, 0, 4'd4, 0, 6'd0,  0, 6'd0};
        vt[5]  = '{0, 0, 0, 0, 6'd0,  6'd0,  0, 1, 4'd0, 4'd3, 1, 0, 4'd4, 0, 6'd0,  0, 6'd0};
        vt[6]  = '{0, 0, 0, 0, 6'd0,  6'd0,  0, 0, 4'd0, 4'd0, 1, 0, 4'd4, 0, 6'd0,  0, 6'd0};
        vt[7]  = '{0, 0, 0, 0, 6'd0,  6'd0,  1, 0, 4'd2, 4'd0, 1, 0, 4'd4, 0, 6'd0,  0, 6'd0};
        vt[8]  = '{0, 0, 0, 0, 6'd0,  6'd0,  0, 0, 4'd0, 4'd0, 1, 1, 4'd4, 1, 6'd9,  1, 6'd11};
        vt[9]  = '{1, 1, 0, 1, 6'd12, 6'd0,  0, 0, 4'd0, 4'd0, 1, 0, 4'd6, 0, 6'd0,  0, 6'd0};
        vt[10] = '{0, 0, 0, 0, 6'd0,  6'd0,  1, 1, 4'd4, 4'd5, 1, 0, 4'd6, 0, 6'd0,  0, 6'd0};
        vt[11] = '{0, 0, 0, 0, 6'd0,  6'd0,  0, 0, 4'd0, 4'd0, 1, 1, 4'd6, 0, 6'd0,  0, 6'd0};
        vt[12] = '{0, 0, 0, 0, 6'd0,  6'd0,  1, 0, 4'd7, 4'd0, 1, 1, 4'd6, 0, 6'd0,  0, 6'd0};
        vt[13] = '{1, 1, 1, 1, 6'd3,  6'd4,  0, 0, 4'd0, 4'd0, 1, 0, 4'd8, 0, 6'd0,  0, 6'd0};
        vt[14] = '{0, 0, 0, 0, 6'd0,  6'd0,  1, 0, 4'd6, 4'd0, 1, 0, 4'd8, 0, 6'd0,  0, 6'd0};
        vt[15] = '{0, 0, 0, 0, 6'd0,  6'd0,  0, 0, 4'd0, 4'd0, 1, 0, 4'd8, 1, 6'd3,  0, 6'd0};
        vt[16] = '{0, 0, 0, 0, 6'd0,  6'd0,  1, 1, 4'd7, 4'd7, 1, 0, 4'd8, 0, 6'd0,  0, 6'd0};
        vt[17] = '{0, 0, 0, 0, 6'd0,  6'd0,  0, 0, 4'd0, 4'd0, 1, 1, 4'd8, 1, 6'd4,  0, 6'd0};
        vt[18] = '{0, 1, 1, 1, 6'd33, 6'd34, 0, 0, 4'd0, 4'd0, 1, 1, 4'd8, 0, 6'd0,  0, 6'd0};

        idle();
        tick();
        tick();
        chk_out("reset", 1, 1, 4'd0, 0, 6'd0, 0, 6'd0);
        rst = 1'b0;

        for (int i = 0; i < 19; i++) begin
            drive(vt[i].dv1, vt[i].dv2, vt[i].hr1, vt[i].hr2, vt[i].pd1, vt[i].pd2,
                  vt[i].cv1, vt[i].cv2, vt[i].ci1, vt[i].ci2);
            tick();
            chk_out($sformatf("vec%0d", i), vt[i].rdy, vt[i].emp, vt[i].idx1,
                    vt[i].f1v, vt[i].f1, vt[i].f2v, vt[i].f2);
        end

        // Fill from head=tail=8 to 16 occupied; ready stays high through 14.
        for (int k = 0; k < 8; k++) begin
            drive(1, 1, 1, 1, 6'(16 + 2 * k), 6'(17 + 2 * k), 0, 0, 4'd0, 4'd0);
            q.push_back(6'(16 + 2 * k));
            q.push_back(6'(17 + 2 * k));
            tick();
            chk_out($sformatf("fill%0d", k), k < 7, 0, 4'(10 + 2 * k), 0, 6'd0, 0, 6'd0);
        end
        drive(1, 1, 1, 1, 6'd50, 6'd51, 0, 0, 4'd0, 4'd0);
        tick();
        chk_out("full_ignored", 0, 0, 4'd8, 0, 6'd0, 0, 6'd0);
        drive(0, 0, 0, 0, 6'd0, 6'd0, 1, 1, 4'd8, 4'd9);
        tick();
        chk_out("full_cmp", 0, 0, 4'd8, 0, 6'd0, 0, 6'd0);
        idle();
        tick();
        e1 = q.pop_front();
        e2 = q.pop_front();
        chk_out("full_retire", 1, 0, 4'd8, 1, e1, 1, e2);

        // Count 14: simultaneous dispatch of 2 and retire of 2.
        drive(0, 0, 0, 0, 6'd0, 6'd0, 1, 1, 4'd10, 4'd11);
        tick();
        chk_out("c14_cmp", 1, 0, 4'd8, 0, 6'd0, 0, 6'd0);
        drive(1, 1, 1, 1, 6'd40, 6'd41, 0, 0, 4'd0, 4'd0);
        q.push_back(6'd40);
        q.push_back(6'd41);
        tick();
        e1 = q.pop_front();
        e2 = q.pop_front();
        chk_out("c14_both", 1, 0, 4'd10, 1, e1, 1, e2);

        // Alloc/retire pairs around the ring, frees must stay in program order.
        hm = 4'd12;
        tm = 4'd10;
        for (int i = 0; i < 20; i++) begin
            drive(1, 1, 1, 1, 6'(2 * i + 1), 6'(2 * i + 2), 1, 1, hm, hm + 4'd1);
            q.push_back(6'(2 * i + 1));
            q.push_back(6'(2 * i + 2));
            tm = tm + 4'd2;
            tick();
            chk_out($sformatf("pair%0d_a", i), 0, 0, tm, 0, 6'd0, 0, 6'd0);
            idle();
            tick();
            e1 = q.pop_front();
            e2 = q.pop_front();
            chk_out($sformatf("pair%0d_b", i), 1, 0, tm, 1, e1, 1, e2);
            hm = hm + 4'd2;
        end

        // Reset with 14 entries in flight and the head pair already completed.
        drive(0, 0, 0, 0, 6'd0, 6'd0, 1, 1, hm, hm + 4'd1);
        tick();
        rst = 1'b1;
        drive(1, 1, 1, 1, 6'd60, 6'd61, 1, 1, hm + 4'd2, hm + 4'd3);
        tick();
        chk_out("rst_mid", 1, 1, 4'd0, 0, 6'd0, 0, 6'd0);
        rst = 1'b0;
        idle();
        tick();
        chk_out("post_rst", 1, 1, 4'd0, 0, 6'd0, 0, 6'd0);
        drive(1, 1, 1, 1, 6'd5, 6'd6, 0, 0, 4'd0, 4'd0);
        tick();
        chk_out("post_rst_disp", 1, 0, 4'd2, 0, 6'd0, 0, 6'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
